// File: rtl/mem_arbiter_rr.sv
// ---------------------------------------------------------------------------
// mem_arbiter_rr
//
// Shares one single-port synchronous RAM between NUM_CORES requesting cores.
// Each transaction is one read or one write. The arbiter uses a rotating
// round-robin pointer, so a port that has just been served gets the lowest
// priority for the next grant.
//
// Transaction shape:
//   IDLE -> ACCESS -> ACK                     (write)
//   IDLE -> ACCESS -> WAIT x RD_LAT -> ACK    (read)
// There is always one IDLE cycle between consecutive transactions.
//
// Ports:
//   clk       system clock, all state updates on the rising edge
//   rst       asynchronous active-high reset
//   rden      per-core read request, bit i = core i
//   wren      per-core write request (wins over rden when both are set)
//   addr      per-core address, slice i = core i
//   din       per-core write data, slice i = core i
//   ram_q     read data returned by the RAM
//   acq       one-cycle completion strobe, one bit per core
//   dq        per-core registered read data, held until that core's next read
//   ram_addr  RAM address, held between transactions
//   ram_din   RAM write data, held between transactions
//   ram_wren  RAM write enable, high only in the ACCESS cycle of a write
//   grant_id  index of the core currently or most recently served
//   busy      high whenever a transaction is in flight (state != IDLE)
// ---------------------------------------------------------------------------
module mem_arbiter_rr #(
  parameter int NUM_CORES = 3,
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 8,
  parameter int RD_LAT    = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_CORES-1:0]          rden,
  input  logic [NUM_CORES-1:0]          wren,
  input  logic [NUM_CORES*ADDR_W-1:0]   addr,
  input  logic [NUM_CORES*DATA_W-1:0]   din,
  input  logic [DATA_W-1:0]             ram_q,
  output logic [NUM_CORES-1:0]          acq,
  output logic [NUM_CORES*DATA_W-1:0]   dq,
  output logic [ADDR_W-1:0]             ram_addr,
  output logic [DATA_W-1:0]             ram_din,
  output logic                          ram_wren,
  output logic [$clog2(NUM_CORES)-1:0]  grant_id,
  output logic                          busy
);

  localparam int IDX_W = $clog2(NUM_CORES);
  // The wait counter must hold RD_LAT-1; keep it at least one bit wide so
  // that RD_LAT = 1 still gives a legal vector.
  localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_CORES - 1);
  localparam logic [IDX_W:0]   NUM_PORTS = (IDX_W + 1)'(NUM_CORES);
  localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(RD_LAT - 1);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WAIT,
    ACK
  } state_t;

  state_t               state;
  state_t               next_state;
  logic [IDX_W-1:0]     ptr;
  logic                 op_write;
  logic [CNT_W-1:0]     wait_cnt;
  logic [NUM_CORES-1:0] req;
  logic                 req_any;
  logic [IDX_W-1:0]     sel_idx;
  logic [IDX_W:0]       scan;

  assign req = rden | wren;

  // Round-robin selection: walk ptr, ptr+1, ... and take the first core that
  // is requesting. The wrap is done by a single conditional subtraction
  // because ptr is always below NUM_CORES, so ptr+k stays below
  // 2*NUM_CORES. This keeps non-power-of-two core counts from ever
  // producing an out-of-range index.
  always_comb begin
    req_any = 1'b0;
    sel_idx = ptr;
    scan    = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      scan = {1'b0, ptr} + (IDX_W + 1)'(k);
      if (scan >= NUM_PORTS) begin
        scan = scan - NUM_PORTS;
      end
      if (!req_any && req[scan[IDX_W-1:0]]) begin
        req_any = 1'b1;
        sel_idx = scan[IDX_W-1:0];
      end
    end
  end

  // State register. Reset drops straight back to IDLE, which also clears
  // ram_wren, acq and busy immediately because they are decoded from state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic and state-decoded outputs. ram_wren, acq and busy are
  // pure decodes of the registered state, so they are glitch-free with
  // respect to the request inputs.
  always_comb begin
    next_state = state;
    ram_wren   = 1'b0;
    acq        = '0;
    busy       = (state != IDLE);
    case (state)
      IDLE: begin
        if (req_any) begin
          next_state = ACCESS;
        end
      end
      ACCESS: begin
        ram_wren   = op_write;
        next_state = op_write ? ACK : WAIT;
      end
      WAIT: begin
        if (wait_cnt == '0) begin
          next_state = ACK;
        end
      end
      ACK: begin
        acq[grant_id] = 1'b1;
        next_state    = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Transaction registers. The winning core's address, data and operation
  // are captured when leaving IDLE so the RAM side stays stable for the
  // whole transaction even if the requester changes its inputs. ram_addr
  // and ram_din are only reloaded on a new grant, so they hold their last
  // values through ACK and IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_id <= '0;
      ram_addr <= '0;
      ram_din  <= '0;
      op_write <= 1'b0;
      wait_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_any) begin
            grant_id <= sel_idx;
            ram_addr <= addr[sel_idx*ADDR_W +: ADDR_W];
            ram_din  <= din[sel_idx*DATA_W +: DATA_W];
            op_write <= wren[sel_idx];
          end
        end
        ACCESS: begin
          wait_cnt <= CNT_LOAD;
        end
        WAIT: begin
          if (wait_cnt != '0) begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Rotating priority pointer. It moves to the core after the one just
  // served, so every other requesting core is ahead of it next time.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (state == ACK) begin
      ptr <= (grant_id == LAST_IDX) ? '0 : grant_id + 1'b1;
    end
  end

  // Per-core read data. Only the served core's slice is written, and only
  // at the end of a read's last WAIT cycle, so writes never disturb dq and
  // the value is already valid during the ACK cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dq <= '0;
    end else if (state == WAIT && wait_cnt == '0) begin
      dq[grant_id*DATA_W +: DATA_W] <= ram_q;
    end
  end

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter_rr
//
// Bench for mem_arbiter_rr. Two instances are exercised:
//   A: NUM_CORES=3, ADDR_W=8, DATA_W=8,  RD_LAT=2 with a registered-address,
//      registered-output RAM model
//   B: NUM_CORES=4, ADDR_W=8, DATA_W=16, RD_LAT=1 with a registered-output
//      RAM model
// Inputs are driven and outputs sampled 1 time unit after the rising edge.
// ---------------------------------------------------------------------------
module tb_mem_arbiter_rr;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  // Instance A signals
  logic [2:0]  rden_a, wren_a, acq_a;
  logic [23:0] addr_a, din_a, dq_a;
  logic [7:0]  ram_q_a, ram_addr_a, ram_din_a;
  logic        ram_wren_a, busy_a;
  logic [1:0]  grant_a;

  // Instance B signals
  logic [3:0]  rden_b, wren_b, acq_b;
  logic [31:0] addr_b;
  logic [63:0] din_b, dq_b;
  logic [15:0] ram_q_b, ram_din_b;
  logic [7:0]  ram_addr_b;
  logic        ram_wren_b, busy_b;
  logic [1:0]  grant_b;

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] exp_dq [2][4];

  mem_arbiter_rr #(
    .NUM_CORES(3), .ADDR_W(8), .DATA_W(8), .RD_LAT(2)
  ) dut_a (
    .clk(clk), .rst(rst), .rden(rden_a), .wren(wren_a), .addr(addr_a),
    .din(din_a), .ram_q(ram_q_a), .acq(acq_a), .dq(dq_a),
    .ram_addr(ram_addr_a), .ram_din(ram_din_a), .ram_wren(ram_wren_a),
    .grant_id(grant_a), .busy(busy_a)
  );

  mem_arbiter_rr #(
    .NUM_CORES(4), .ADDR_W(8), .DATA_W(16), .RD_LAT(1)
  ) dut_b (
    .clk(clk), .rst(rst), .rden(rden_b), .wren(wren_b), .addr(addr_b),
    .din(din_b), .ram_q(ram_q_b), .acq(acq_b), .dq(dq_b),
    .ram_addr(ram_addr_b), .ram_din(ram_din_b), .ram_wren(ram_wren_b),
    .grant_id(grant_b), .busy(busy_b)
  );

  // RAM A: address registered, then output registered (two-cycle read)
  logic [7:0] mem_a [256];
  logic [7:0] raddr_a;
  always_ff @(posedge clk) begin
    if (ram_wren_a) mem_a[ram_addr_a] <= ram_din_a;
    raddr_a <= ram_addr_a;
    ram_q_a <= mem_a[raddr_a];
  end

  // RAM B: output registered (one-cycle read)
  logic [15:0] mem_b [256];
  always_ff @(posedge clk) begin
    if (ram_wren_b) mem_b[ram_addr_b] <= ram_din_b;
    ram_q_b <= mem_b[ram_addr_b];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int dut, input int port, input logic rd,
                               input logic wr, input logic [7:0] a,
                               input logic [15:0] d);
    if (dut == 0) begin
      rden_a[port]          = rd;
      wren_a[port]          = wr;
      addr_a[port*8 +: 8]   = a;
      din_a[port*8 +: 8]    = d[7:0];
    end else begin
      rden_b[port]          = rd;
      wren_b[port]          = wr;
      addr_b[port*8 +: 8]   = a;
      din_b[port*16 +: 16]  = d;
    end
  endtask

  function automatic logic [3:0] getAcq(input int dut);
    return (dut == 0) ? {1'b0, acq_a} : acq_b;
  endfunction

  function automatic logic [1:0] getGrant(input int dut);
    return (dut == 0) ? grant_a : grant_b;
  endfunction

  function automatic logic [15:0] getDq(input int dut, input int p);
    return (dut == 0) ? {8'h00, dq_a[p*8 +: 8]} : dq_b[p*16 +: 16];
  endfunction

  // One transaction from an IDLE cycle; returns in the IDLE cycle after ACK.
  task automatic runTxn(input int dut, input int port, input logic rd,
                        input logic wr, input logic [7:0] a,
                        input logic [15:0] d, input int exp_lat,
                        input string tag);
    int lat;
    lat = 0;
    applyStimulus(dut, port, rd, wr, a, d);
    while (lat < 20 && getAcq(dut) == 4'd0) begin
      tick();
      lat++;
    end
    checkOutput({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    checkOutput({tag, "_acq"}, 64'(getAcq(dut)), 64'(1 << port));
    applyStimulus(dut, port, 1'b0, 1'b0, a, d);
    tick();
  endtask

  // All ports already requesting with ptr at 0: grants must rotate 0,1,...
  task automatic runContention(input int dut, input int n_ports,
                               input int n_grants, input int gap,
                               input int first_lat, input string tag);
    int seen, cyc, last, p;
    seen = 0;
    cyc  = 0;
    last = 0;
    while (seen < n_grants && cyc < 100) begin
      tick();
      cyc++;
      if (getAcq(dut) != 4'd0) begin
        p = seen % n_ports;
        checkOutput($sformatf("%s_grant%0d", tag, seen), 64'(getGrant(dut)), 64'(p));
        checkOutput($sformatf("%s_acq%0d", tag, seen), 64'(getAcq(dut)), 64'(1 << p));
        checkOutput($sformatf("%s_dq%0d", tag, seen), 64'(getDq(dut, p)), 64'(exp_dq[dut][p]));
        checkOutput($sformatf("%s_gap%0d", tag, seen), 64'(cyc - last),
                    64'((seen == 0) ? first_lat : gap));
        last = cyc;
        seen++;
      end
    end
    checkOutput({tag, "_count"}, 64'(seen), 64'(n_grants));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int idle_bad;

    exp_dq[0][0] = 16'h0011;
    exp_dq[0][1] = 16'h0022;
    exp_dq[0][2] = 16'h0033;
    exp_dq[0][3] = 16'h0000;
    for (int k = 0; k < 4; k++) exp_dq[1][k] = 16'(16'hA000 + k);

    rst    = 1'b1;
    rden_a = '0; wren_a = '0; addr_a = '0; din_a = '0;
    rden_b = '0; wren_b = '0; addr_b = '0; din_b = '0;
    repeat (2) tick();
    rst = 1'b0;
    tick();

    // Reset asserted while idle with random inputs
    rden_a = 3'($urandom); wren_a = 3'($urandom);
    addr_a = 24'($urandom); din_a = 24'($urandom);
    rden_b = 4'($urandom); wren_b = 4'($urandom);
    addr_b = $urandom; din_b = {$urandom, $urandom};
    rst = 1'b1;
    repeat (2) tick();
    checkOutput("rst_acq", 64'(acq_a), 64'(0));
    checkOutput("rst_dq", 64'(dq_a), 64'(0));
    checkOutput("rst_wren", 64'(ram_wren_a), 64'(0));
    checkOutput("rst_addr", 64'(ram_addr_a), 64'(0));
    checkOutput("rst_din", 64'(ram_din_a), 64'(0));
    checkOutput("rst_busy", 64'(busy_a), 64'(0));
    checkOutput("rst_grant", 64'(grant_a), 64'(0));
    checkOutput("rst_b_busy", 64'(busy_b), 64'(0));
    checkOutput("rst_b_acq", 64'(acq_b), 64'(0));
    rden_a = '0; wren_a = '0; addr_a = '0; din_a = '0;
    rden_b = '0; wren_b = '0; addr_b = '0; din_b = '0;
    rst = 1'b0;
    tick();

    // Write: core1, addr 0x10, data 0xA5
    applyStimulus(0, 1, 1'b0, 1'b1, 8'h10, 16'h00A5);
    checkOutput("wr_t0_busy", 64'(busy_a), 64'(0));
    tick();
    checkOutput("wr_t1_wren", 64'(ram_wren_a), 64'(1));
    checkOutput("wr_t1_addr", 64'(ram_addr_a), 64'(8'h10));
    checkOutput("wr_t1_din", 64'(ram_din_a), 64'(8'hA5));
    checkOutput("wr_t1_acq", 64'(acq_a), 64'(0));
    checkOutput("wr_t1_grant", 64'(grant_a), 64'(1));
    checkOutput("wr_t1_busy", 64'(busy_a), 64'(1));
    tick();
    checkOutput("wr_t2_acq", 64'(acq_a), 64'(3'b010));
    checkOutput("wr_t2_wren", 64'(ram_wren_a), 64'(0));
    checkOutput("wr_t2_dq", 64'(dq_a), 64'(0));
    applyStimulus(0, 1, 1'b0, 1'b0, 8'h10, 16'h00A5);
    tick();
    checkOutput("wr_t3_acq", 64'(acq_a), 64'(0));
    checkOutput("wr_t3_busy", 64'(busy_a), 64'(0));
    checkOutput("wr_t3_addr_hold", 64'(ram_addr_a), 64'(8'h10));
    checkOutput("wr_t3_grant_hold", 64'(grant_a), 64'(1));

    // Read: core0, addr 0x10 -> 0xA5 at T+4
    applyStimulus(0, 0, 1'b1, 1'b0, 8'h10, 16'h0000);
    repeat (3) tick();
    checkOutput("rd_t3_acq", 64'(acq_a), 64'(0));
    checkOutput("rd_t3_busy", 64'(busy_a), 64'(1));
    checkOutput("rd_t3_wren", 64'(ram_wren_a), 64'(0));
    tick();
    checkOutput("rd_t4_acq", 64'(acq_a), 64'(3'b001));
    checkOutput("rd_t4_dq0", 64'(dq_a[7:0]), 64'(8'hA5));
    checkOutput("rd_t4_dq_other", 64'(dq_a[23:8]), 64'(0));
    applyStimulus(0, 0, 1'b0, 1'b0, 8'h10, 16'h0000);
    tick();

    // Collision: core2 rden and wren together is a write
    runTxn(0, 2, 1'b1, 1'b1, 8'h20, 16'h003C, 2, "coll");
    checkOutput("coll_dq2", 64'(dq_a[23:16]), 64'(0));
    runTxn(0, 2, 1'b1, 1'b0, 8'h20, 16'h0000, 4, "coll_rd");
    checkOutput("coll_rd_dq2", 64'(dq_a[23:16]), 64'(8'h3C));

    // Contention on A after a fresh reset
    runTxn(0, 0, 1'b0, 1'b1, 8'h01, 16'h0011, 2, "w1");
    runTxn(0, 1, 1'b0, 1'b1, 8'h02, 16'h0022, 2, "w2");
    runTxn(0, 2, 1'b0, 1'b1, 8'h03, 16'h0033, 2, "w3");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    applyStimulus(0, 0, 1'b1, 1'b0, 8'h01, 16'h0000);
    applyStimulus(0, 1, 1'b1, 1'b0, 8'h02, 16'h0000);
    applyStimulus(0, 2, 1'b1, 1'b0, 8'h03, 16'h0000);
    runContention(0, 3, 4, 5, 4, "cont_a");
    rden_a = '0;
    tick();

    // Reset during WAIT: ptr is 1 here, so core1 is served
    applyStimulus(0, 1, 1'b1, 1'b0, 8'h02, 16'h0000);
    repeat (2) tick();
    checkOutput("rstw_busy_before", 64'(busy_a), 64'(1));
    checkOutput("rstw_grant_before", 64'(grant_a), 64'(1));
    rst = 1'b1;
    #1;
    checkOutput("rstw_busy", 64'(busy_a), 64'(0));
    checkOutput("rstw_acq", 64'(acq_a), 64'(0));
    checkOutput("rstw_grant", 64'(grant_a), 64'(0));
    checkOutput("rstw_dq", 64'(dq_a), 64'(0));
    applyStimulus(0, 1, 1'b0, 1'b0, 8'h02, 16'h0000);
    tick();
    rst = 1'b0;
    idle_bad = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (acq_a != 3'b000 || busy_a != 1'b0) idle_bad++;
    end
    checkOutput("rstw_no_acq", 64'(idle_bad), 64'(0));
    applyStimulus(0, 1, 1'b1, 1'b0, 8'h02, 16'h0000);
    runTxn(0, 0, 1'b1, 1'b0, 8'h01, 16'h0000, 4, "rstw_first0");
    runTxn(0, 1, 1'b1, 1'b0, 8'h02, 16'h0000, 4, "rstw_next1");
    checkOutput("rstw_next1_dq1", 64'(dq_a[15:8]), 64'(8'h22));

    // Instance B: writes from every port, pointer wraps 3 -> 0
    for (int k = 0; k < 4; k++) begin
      runTxn(1, k, 1'b0, 1'b1, 8'(8'h40 + k), 16'(16'hA000 + k), 2,
             $sformatf("b_wr%0d", k));
    end
    checkOutput("b_grant_hold", 64'(grant_b), 64'(3));
    checkOutput("b_dq_untouched", 64'(dq_b), 64'(0));
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1, k, 1'b1, 1'b0, 8'(8'h40 + k), 16'h0000);
    end
    runContention(1, 4, 5, 4, 3, "cont_b");
    rden_b = '0;
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
